// File: rtl/ahb_bus_arbiter_pkg.sv
// Shared AHB-lite encodings for the two-master peripheral bus arbiter.
package ahb_bus_arbiter_pkg;
  localparam int WORD_WIDTH = 32;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;
endpackage

// File: rtl/ahb_bus_arbiter.sv
// Two-master AHB-lite arbiter (M0 = CPU LSU, M1 = debug/DMA) in front of the peripheral decoder.
// Grant moves only when the owner drives IDLE on a ready cycle, so bursts are never split.
module ahb_bus_arbiter
  import ahb_bus_arbiter_pkg::*;
#(
  parameter bit DEFAULT_GRANT = 1'b0,
  parameter int AW            = WORD_WIDTH,
  parameter int DW            = WORD_WIDTH
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] M0_HADDR,
  input  logic [1:0]    M0_HTRANS,
  input  logic          M0_HWRITE,
  input  logic [2:0]    M0_HSIZE,
  input  logic [DW-1:0] M0_HWDATA,
  output logic [DW-1:0] M0_HRDATA,
  output logic          M0_HREADY,
  output logic [1:0]    M0_HRESP,
  input  logic [AW-1:0] M1_HADDR,
  input  logic [1:0]    M1_HTRANS,
  input  logic          M1_HWRITE,
  input  logic [2:0]    M1_HSIZE,
  input  logic [DW-1:0] M1_HWDATA,
  output logic [DW-1:0] M1_HRDATA,
  output logic          M1_HREADY,
  output logic [1:0]    M1_HRESP,
  output logic [AW-1:0] BUS_HADDR,
  output logic [1:0]    BUS_HTRANS,
  output logic          BUS_HWRITE,
  output logic [2:0]    BUS_HSIZE,
  output logic [DW-1:0] BUS_HWDATA,
  input  logic [DW-1:0] BUS_HRDATA,
  input  logic          BUS_HREADY,
  input  logic [1:0]    BUS_HRESP,
  output logic          HMASTER
);
  logic       grant, dp_valid, dp_owner;
  logic [1:0] req, gnt_oh, dp_mine, ready;
  logic       other_req, do_switch;

  assign req     = {M1_HTRANS[1], M0_HTRANS[1]};
  assign gnt_oh  = {grant, ~grant};
  assign dp_mine = {dp_valid & dp_owner, dp_valid & ~dp_owner};

  // Address phase follows the grant with no register stage.
  assign BUS_HADDR  = grant ? M1_HADDR  : M0_HADDR;
  assign BUS_HTRANS = grant ? M1_HTRANS : M0_HTRANS;
  assign BUS_HWRITE = grant ? M1_HWRITE : M0_HWRITE;
  assign BUS_HSIZE  = grant ? M1_HSIZE  : M0_HSIZE;
  assign BUS_HWDATA = dp_owner ? M1_HWDATA : M0_HWDATA;
  assign HMASTER    = grant;

  assign other_req = grant ? req[0] : req[1];
  assign do_switch = BUS_HREADY && (BUS_HTRANS == HTRANS_IDLE) && other_req;

  // A master involved in either phase sees the bus ready; a parked requester is stalled.
  always_comb begin
    ready = '0;
    for (int i = 0; i < 2; i++)
      ready[i] = (gnt_oh[i] | dp_mine[i]) ? BUS_HREADY : ~req[i];
  end

  assign M0_HREADY = ready[0];
  assign M1_HREADY = ready[1];
  assign M0_HRDATA = BUS_HRDATA;
  assign M1_HRDATA = BUS_HRDATA;
  assign M0_HRESP  = dp_mine[0] ? BUS_HRESP : HRESP_OKAY;
  assign M1_HRESP  = dp_mine[1] ? BUS_HRESP : HRESP_OKAY;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant    <= DEFAULT_GRANT;
      dp_valid <= 1'b0;
      dp_owner <= DEFAULT_GRANT;
    end else if (BUS_HREADY) begin
      dp_valid <= BUS_HTRANS[1];
      dp_owner <= grant;
      if (do_switch) grant <= ~grant;
    end
  end
endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Directed vector bench for ahb_bus_arbiter: one table row per clock cycle plus a reset sequence.
module tb_ahb_bus_arbiter;
  localparam logic [31:0] M0_WD = 32'h1111_0000;
  localparam logic [31:0] M1_WD = 32'h0000_00A5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] m0_haddr, m1_haddr, m0_hwdata, m1_hwdata, m0_hrdata, m1_hrdata;
  logic [1:0]  m0_htrans, m1_htrans, m0_hresp, m1_hresp;
  logic        m0_hwrite, m1_hwrite, m0_hready, m1_hready;
  logic [2:0]  m0_hsize, m1_hsize;
  logic [31:0] bus_haddr, bus_hwdata, bus_hrdata;
  logic [1:0]  bus_htrans, bus_hresp;
  logic        bus_hwrite, bus_hready, hmaster;
  logic [2:0]  bus_hsize;

  ahb_bus_arbiter #(.DEFAULT_GRANT(1'b0), .AW(32), .DW(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .M0_HADDR(m0_haddr), .M0_HTRANS(m0_htrans), .M0_HWRITE(m0_hwrite), .M0_HSIZE(m0_hsize),
    .M0_HWDATA(m0_hwdata), .M0_HRDATA(m0_hrdata), .M0_HREADY(m0_hready), .M0_HRESP(m0_hresp),
    .M1_HADDR(m1_haddr), .M1_HTRANS(m1_htrans), .M1_HWRITE(m1_hwrite), .M1_HSIZE(m1_hsize),
    .M1_HWDATA(m1_hwdata), .M1_HRDATA(m1_hrdata), .M1_HREADY(m1_hready), .M1_HRESP(m1_hresp),
    .BUS_HADDR(bus_haddr), .BUS_HTRANS(bus_htrans), .BUS_HWRITE(bus_hwrite), .BUS_HSIZE(bus_hsize),
    .BUS_HWDATA(bus_hwdata), .BUS_HRDATA(bus_hrdata), .BUS_HREADY(bus_hready), .BUS_HRESP(bus_hresp),
    .HMASTER(hmaster)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  m0_tr;
    logic [31:0] m0_ad;
    logic [1:0]  m1_tr;
    logic [31:0] m1_ad;
    logic        rdy;
    logic [1:0]  resp;
    logic        e_gnt;
    logic [31:0] e_haddr;
    logic [1:0]  e_htrans;
    logic        e_r0, e_r1;
    logic [1:0]  e_p0, e_p1;
    logic        e_dpo;
  } vec_t;

  localparam int NV = 22;
  vec_t vec [NV];
  int   total = 0, passed = 0;

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s (step %0d): got %h, expected %h", nm, idx, act, exp);
    else passed++;
  endtask

  task automatic drive(input vec_t v, input logic [31:0] rd);
    m0_htrans = v.m0_tr; m0_haddr = v.m0_ad;
    m1_htrans = v.m1_tr; m1_haddr = v.m1_ad;
    bus_hready = v.rdy; bus_hresp = v.resp; bus_hrdata = rd;
  endtask

  initial begin
    // m0_tr m0_ad          m1_tr m1_ad        rdy resp | gnt haddr          htrans r0 r1 p0 p1 dpo
    vec[0]  = '{2'b00, 32'h0,          2'b00, 32'h0,          1, 2'b00, 0, 32'h0,          2'b00, 1, 1, 2'b00, 2'b00, 0};
    vec[1]  = '{2'b10, 32'h0200_0000,  2'b00, 32'h0,          1, 2'b00, 0, 32'h0200_0000,  2'b10, 1, 1, 2'b00, 2'b00, 0};
    vec[2]  = '{2'b00, 32'h0,          2'b10, 32'h1001_3000,  1, 2'b00, 0, 32'h0,          2'b00, 1, 0, 2'b00, 2'b00, 0};
    vec[3]  = '{2'b00, 32'h0,          2'b10, 32'h1001_3000,  1, 2'b00, 1, 32'h1001_3000,  2'b10, 1, 1, 2'b00, 2'b00, 0};
    vec[4]  = '{2'b00, 32'h0,          2'b00, 32'h0,          1, 2'b00, 1, 32'h0,          2'b00, 1, 1, 2'b00, 2'b00, 1};
    vec[5]  = '{2'b10, 32'h0200_0010,  2'b00, 32'h0,          1, 2'b00, 1, 32'h0,          2'b00, 0, 1, 2'b00, 2'b00, 1};
    vec[6]  = '{2'b10, 32'h0200_0010,  2'b10, 32'h1001_3008,  1, 2'b00, 0, 32'h0200_0010,  2'b10, 1, 0, 2'b00, 2'b00, 1};
    vec[7]  = '{2'b10, 32'h0200_0014,  2'b10, 32'h1001_3008,  1, 2'b00, 0, 32'h0200_0014,  2'b10, 1, 0, 2'b00, 2'b00, 0};
    vec[8]  = '{2'b11, 32'h0200_0018,  2'b10, 32'h1001_3008,  1, 2'b00, 0, 32'h0200_0018,  2'b11, 1, 0, 2'b00, 2'b00, 0};
    vec[9]  = '{2'b00, 32'h0,          2'b10, 32'h1001_3008,  1, 2'b00, 0, 32'h0,          2'b00, 1, 0, 2'b00, 2'b00, 0};
    vec[10] = '{2'b00, 32'h0,          2'b10, 32'h1001_3008,  1, 2'b00, 1, 32'h1001_3008,  2'b10, 1, 1, 2'b00, 2'b00, 0};
    vec[11] = '{2'b00, 32'h0,          2'b00, 32'h0,          0, 2'b01, 1, 32'h0,          2'b00, 1, 0, 2'b00, 2'b01, 1};
    vec[12] = '{2'b00, 32'h0,          2'b00, 32'h0,          1, 2'b01, 1, 32'h0,          2'b00, 1, 1, 2'b00, 2'b01, 1};
    vec[13] = '{2'b10, 32'h0200_0020,  2'b00, 32'h0,          1, 2'b00, 1, 32'h0,          2'b00, 0, 1, 2'b00, 2'b00, 1};
    vec[14] = '{2'b10, 32'h0200_0020,  2'b00, 32'h0,          1, 2'b00, 0, 32'h0200_0020,  2'b10, 1, 1, 2'b00, 2'b00, 1};
    vec[15] = '{2'b10, 32'h0200_0024,  2'b10, 32'h1001_3010,  0, 2'b00, 0, 32'h0200_0024,  2'b10, 0, 0, 2'b00, 2'b00, 0};
    vec[16] = '{2'b10, 32'h0200_0024,  2'b10, 32'h1001_3010,  0, 2'b00, 0, 32'h0200_0024,  2'b10, 0, 0, 2'b00, 2'b00, 0};
    vec[17] = '{2'b10, 32'h0200_0024,  2'b10, 32'h1001_3010,  1, 2'b00, 0, 32'h0200_0024,  2'b10, 1, 0, 2'b00, 2'b00, 0};
    vec[18] = '{2'b00, 32'h0,          2'b10, 32'h1001_3010,  1, 2'b00, 0, 32'h0,          2'b00, 1, 0, 2'b00, 2'b00, 0};
    vec[19] = '{2'b10, 32'h0200_0030,  2'b10, 32'h1001_3010,  1, 2'b00, 1, 32'h1001_3010,  2'b10, 0, 1, 2'b00, 2'b00, 0};
    vec[20] = '{2'b10, 32'h0200_0030,  2'b00, 32'h0,          1, 2'b00, 1, 32'h0,          2'b00, 0, 1, 2'b00, 2'b00, 1};
    vec[21] = '{2'b10, 32'h0200_0030,  2'b00, 32'h0,          1, 2'b00, 0, 32'h0200_0030,  2'b10, 1, 1, 2'b00, 2'b00, 1};

    m0_hwrite = 1'b0; m0_hsize = 3'b010; m0_hwdata = M0_WD;
    m1_hwrite = 1'b1; m1_hsize = 3'b010; m1_hwdata = M1_WD;
    rst_n = 1'b0;
    drive(vec[0], 32'h0);
    #2;
    chk("rst_hmaster", -1, 32'(hmaster), 32'h0);
    chk("rst_htrans",  -1, 32'(bus_htrans), 32'h0);
    chk("rst_m0_hready", -1, 32'(m0_hready), 32'h1);
    chk("rst_m1_hready", -1, 32'(m1_hready), 32'h1);
    chk("rst_m1_hresp",  -1, 32'(m1_hresp), 32'h0);
    m1_htrans = 2'b10;
    #1;
    chk("rst_m1_req_stall", -1, 32'(m1_hready), 32'h0);
    m1_htrans = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vec[i], 32'hD000_0000 + 32'(i));
      #1;
      chk("hmaster",    i, 32'(hmaster),    32'(vec[i].e_gnt));
      chk("bus_haddr",  i, bus_haddr,       vec[i].e_haddr);
      chk("bus_htrans", i, 32'(bus_htrans), 32'(vec[i].e_htrans));
      chk("bus_hwrite", i, 32'(bus_hwrite), 32'(vec[i].e_gnt));
      chk("m0_hready",  i, 32'(m0_hready),  32'(vec[i].e_r0));
      chk("m1_hready",  i, 32'(m1_hready),  32'(vec[i].e_r1));
      chk("m0_hresp",   i, 32'(m0_hresp),   32'(vec[i].e_p0));
      chk("m1_hresp",   i, 32'(m1_hresp),   32'(vec[i].e_p1));
      chk("bus_hwdata", i, bus_hwdata,      vec[i].e_dpo ? M1_WD : M0_WD);
      chk("m0_hrdata",  i, m0_hrdata,       32'hD000_0000 + 32'(i));
      chk("m1_hrdata",  i, m1_hrdata,       32'hD000_0000 + 32'(i));
    end

    // Hand M1 the bus, open its data phase, then pull reset between edges.
    @(negedge clk);
    m0_htrans = 2'b00; m0_haddr = 32'h0200_0040;
    m1_htrans = 2'b10; m1_haddr = 32'h1001_3020; bus_hready = 1'b1; bus_hresp = 2'b00;
    @(negedge clk);
    #1;
    chk("seq_m1_granted", 100, 32'(hmaster), 32'h1);
    @(negedge clk);
    bus_hresp = 2'b01;
    #1;
    chk("seq_m1_dp_resp", 101, 32'(m1_hresp), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("seq_rst_hmaster", 102, 32'(hmaster), 32'h0);
    chk("seq_rst_haddr",   102, bus_haddr, 32'h0200_0040);
    chk("seq_rst_m1_resp", 102, 32'(m1_hresp), 32'h0);
    chk("seq_rst_m1_rdy",  102, 32'(m1_hready), 32'h0);
    chk("seq_rst_hwdata",  102, bus_hwdata, M0_WD);
    @(negedge clk);
    rst_n = 1'b1; bus_hresp = 2'b00;
    @(negedge clk);
    #1;
    chk("seq_post_rst_switch", 103, 32'(hmaster), 32'h1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
